// File: rtl/commit_trace_encoder.sv
// Commit trace encoder: taps CPU writeback, tags each post-warm-up cycle with a
// sequence number, buffers it in a FIFO and streams it out as 32-bit words.
module commit_trace_encoder #(
  parameter int DEPTH       = 16,
  parameter int SKIP_CYCLES = 5,
  parameter int SEQ_W       = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_we,
  input  logic [4:0]  reg_waddr,
  input  logic [31:0] reg_wdata,
  input  logic        hilo_we,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_data,
  output logic        trace_last,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int WARM_W = $clog2(SKIP_CYCLES + 2);

  typedef enum logic [1:0] {K_SKIP = 2'd0, K_REG = 2'd1, K_HILO = 2'd2, K_CP0 = 2'd3} kind_t;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_D0, S_D1} state_t;

  typedef struct packed {
    kind_t             kind;
    logic [4:0]        addr;
    logic [SEQ_W-1:0]  seq;
    logic [31:0]       d0;
    logic [31:0]       d1;
  } event_t;

  logic [WARM_W-1:0] warm_cnt;
  logic              active;
  logic [SEQ_W-1:0]  seq;
  event_t            ev;

  event_t            mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, push, pop, drop;

  state_t            state, state_n;
  event_t            hold;

  assign active = (warm_cnt == WARM_W'(SKIP_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt <= '0;
      seq      <= SEQ_W'(1);
    end else if (!active) begin
      warm_cnt <= warm_cnt + 1'b1;
    end else begin
      // Advances on dropped events too, so gaps in the trace expose the loss.
      seq <= seq + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ev     = '0;
    ev.seq = seq;
    if (reg_we) begin
      ev.kind = K_REG;
      ev.addr = reg_waddr;
      ev.d0   = reg_wdata;
    end else if (hilo_we) begin
      ev.kind = K_HILO;
      ev.d0   = hi_i;
      ev.d1   = lo_i;
    end else if (cp0_we) begin
      ev.kind = K_CP0;
      ev.addr = cp0_waddr;
      ev.d0   = cp0_wdata;
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == S_IDLE) && !empty;
  assign push  = active && (!full || pop);
  assign drop  = active && full && !pop;

  // NOTE: storage array is deliberately not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      hold       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    trace_valid = 1'b0;
    trace_data  = '0;
    trace_last  = 1'b0;
    case (state)
      S_IDLE: if (!empty) state_n = S_HDR;
      S_HDR: begin
        trace_valid = 1'b1;
        trace_data  = {hold.kind, hold.addr, hold.seq};
        trace_last  = (hold.kind == K_SKIP);
        if (trace_ready) state_n = (hold.kind == K_SKIP) ? S_IDLE : S_D0;
      end
      S_D0: begin
        trace_valid = 1'b1;
        trace_data  = hold.d0;
        trace_last  = (hold.kind != K_HILO);
        if (trace_ready) state_n = (hold.kind == K_HILO) ? S_D1 : S_IDLE;
      end
      S_D1: begin
        trace_valid = 1'b1;
        trace_data  = hold.d1;
        trace_last  = 1'b1;
        if (trace_ready) state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_commit_trace_encoder.sv
// Scoreboard bench for commit_trace_encoder: a per-cycle model queues expected
// words; a negedge monitor captures accepted words for in-order comparison.
module tb_commit_trace_encoder;

  localparam int DEPTH = 16;
  localparam int SKIP  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_we = 1'b0, hilo_we = 1'b0, cp0_we = 1'b0;
  logic [4:0]  reg_waddr = '0, cp0_waddr = '0;
  logic [31:0] reg_wdata = '0, hi_i = '0, lo_i = '0, cp0_wdata = '0;
  logic        trace_valid, trace_last, overflow;
  logic        trace_ready = 1'b1;
  logic [31:0] trace_data;
  logic [15:0] drop_count;

  int          checks = 0;
  int          errors = 0;
  int          warm   = 0;
  logic [24:0] seq    = 25'd1;
  bit          model_on = 1'b1;
  logic [32:0] exp_q[$];
  logic [32:0] rx_q[$];

  always #5 clk = ~clk;

  commit_trace_encoder #(.DEPTH(DEPTH), .SKIP_CYCLES(SKIP), .SEQ_W(25)) dut (
    .clk(clk), .rst(rst),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .hilo_we(hilo_we), .hi_i(hi_i), .lo_i(lo_i),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_data(trace_data), .trace_last(trace_last),
    .overflow(overflow), .drop_count(drop_count)
  );

  // Words are accepted at the next rising edge; inputs only change 1 ns after it.
  always @(negedge clk) begin
    if (rst) rx_q.delete();
    else if (trace_valid && trace_ready) rx_q.push_back({trace_last, trace_data});
  end

  task automatic set_idle();
    reg_we = 1'b0; hilo_we = 1'b0; cp0_we = 1'b0;
  endtask

  // One clock: classify the current inputs and queue the words they should yield.
  task automatic step();
    logic [1:0]  k;
    logic [4:0]  a;
    logic [31:0] d0, d1;
    k = 2'd0; a = '0; d0 = '0; d1 = '0;
    if (reg_we)       begin k = 2'd1; a = reg_waddr; d0 = reg_wdata; end
    else if (hilo_we) begin k = 2'd2; d0 = hi_i; d1 = lo_i; end
    else if (cp0_we)  begin k = 2'd3; a = cp0_waddr; d0 = cp0_wdata; end
    @(posedge clk);
    if (rst) begin
      warm = 0;
      seq  = 25'd1;
    end else if (warm < SKIP) begin
      warm++;
    end else begin
      if (model_on) begin
        exp_q.push_back({(k == 2'd0), k, a, seq});
        if (k != 2'd0) exp_q.push_back({(k != 2'd2), d0});
        if (k == 2'd2) exp_q.push_back({1'b1, d1});
      end
      seq++;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    set_idle();
    repeat (n) step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    trace_ready = 1'b1;
    rst = 1'b1;
    set_idle();
    repeat (10) step();
    checks += 5;
    if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", trace_valid); end
    if (trace_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", trace_data); end
    if (trace_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", trace_last); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop_count: got %h want 0", drop_count); end
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_warmup_reg();
    repeat (SKIP) begin
      step();
      checks++;
      if (trace_valid !== 1'b0) begin errors++; $display("FAIL warmup_valid: got %b want 0", trace_valid); end
    end
    reg_we = 1'b1; reg_waddr = 5'd3; reg_wdata = 32'h0000_1234;
    step();
    set_idle();
    for (int t = 0; t < 100 && rx_q.size() < 3; t++) step();
    checks++;
    if (rx_q.size() < 3) begin
      errors++; $display("FAIL reg_timeout: got %0d words want 3", rx_q.size());
    end else begin
      checks += 2;
      if (rx_q[0] !== 33'h0_4600_0001) begin errors++; $display("FAIL reg_header: got %h want 046000001", rx_q[0]); end
      if (rx_q[1] !== 33'h1_0000_1234) begin errors++; $display("FAIL reg_data: got %h want 100001234", rx_q[1]); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL reg_word[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_hilo_backpressure();
    bit found;
    do_reset(3);
    trace_ready = 1'b1;
    repeat (SKIP) step();
    step();
    hilo_we = 1'b1; hi_i = 32'hDEAD_BEEF; lo_i = 32'h0000_0001;
    step();
    set_idle();
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (trace_valid && trace_data[31:30] == 2'd2) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL hilo_header_seen: got none want 80000002"); end
    trace_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks += 3;
      if (trace_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", c, trace_valid); end
      if (trace_data !== 32'h8000_0002) begin errors++; $display("FAIL stall_data[%0d]: got %h want 80000002", c, trace_data); end
      if (trace_last !== 1'b0) begin errors++; $display("FAIL stall_last[%0d]: got %b want 0", c, trace_last); end
      step();
    end
    trace_ready = 1'b1;
    for (int t = 0; t < 100 && rx_q.size() < 5; t++) step();
    checks++;
    if (rx_q.size() < 5) begin
      errors++; $display("FAIL hilo_timeout: got %0d words want 5", rx_q.size());
    end else begin
      checks += 2;
      if (rx_q[2] !== 33'h0_DEAD_BEEF) begin errors++; $display("FAIL hilo_hi: got %h want 0deadbeef", rx_q[2]); end
      if (rx_q[3] !== 33'h1_0000_0001) begin errors++; $display("FAIL hilo_lo: got %h want 100000001", rx_q[3]); end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL hilo_word[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_priority();
    do_reset(3);
    trace_ready = 1'b1;
    repeat (SKIP) step();
    reg_we = 1'b1; reg_waddr = 5'd7; reg_wdata = 32'hAAAA_5555;
    hilo_we = 1'b1; hi_i = 32'h1111_1111; lo_i = 32'h2222_2222;
    cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h3333_3333;
    step();
    set_idle();
    for (int t = 0; t < 100 && rx_q.size() < 3; t++) step();
    checks++;
    if (rx_q.size() < 3) begin
      errors++; $display("FAIL prio_timeout: got %0d words want 3", rx_q.size());
    end else begin
      checks += 2;
      if (rx_q[0] !== 33'h0_4E00_0001) begin errors++; $display("FAIL prio_header: got %h want 04e000001", rx_q[0]); end
      if (rx_q[2] !== 33'h1_0000_0002) begin errors++; $display("FAIL prio_next_skip: got %h want 100000002", rx_q[2]); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL prio_word[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_cp0_skip();
    do_reset(3);
    trace_ready = 1'b1;
    repeat (SKIP) step();
    cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h1000_0001;
    step();
    set_idle();
    for (int t = 0; t < 100 && rx_q.size() < 3; t++) step();
    checks++;
    if (rx_q.size() < 3) begin
      errors++; $display("FAIL cp0_timeout: got %0d words want 3", rx_q.size());
    end else begin
      checks += 3;
      if (rx_q[0] !== 33'h0_D800_0001) begin errors++; $display("FAIL cp0_header: got %h want 0d8000001", rx_q[0]); end
      if (rx_q[1] !== 33'h1_1000_0001) begin errors++; $display("FAIL cp0_data: got %h want 110000001", rx_q[1]); end
      if (rx_q[2] !== 33'h1_0000_0002) begin errors++; $display("FAIL cp0_skip: got %h want 100000002", rx_q[2]); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL cp0_word[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  // Stalled from reset: record 1 sits in the serializer, records 2..17 fill the
  // FIFO, and events 18..20 are lost before the first pop frees a slot for 21.
  task automatic test_overflow();
    trace_ready = 1'b0;
    do_reset(3);
    model_on = 1'b0;
    repeat (SKIP) step();
    for (int p = 1; p <= DEPTH + 3; p++) begin
      step();
      if (p == DEPTH + 1) begin
        checks += 2;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_full: got %b want 0", overflow); end
        if (drop_count !== 16'd0) begin errors++; $display("FAIL drops_before_full: got %0d want 0", drop_count); end
      end
      if (p == DEPTH + 2) begin
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_first_drop: got %b want 1", overflow); end
        if (drop_count !== 16'd1) begin errors++; $display("FAIL drops_first: got %0d want 1", drop_count); end
      end
    end
    trace_ready = 1'b1;
    step();
    step();
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    if (drop_count !== 16'd3) begin errors++; $display("FAIL drop_count: got %0d want 3", drop_count); end
    for (int s = 1; s <= DEPTH + 1; s++) exp_q.push_back({1'b1, 7'd0, 25'(s)});
    exp_q.push_back({1'b1, 7'd0, 25'(DEPTH + 5)});
    for (int t = 0; t < 200 && rx_q.size() < DEPTH + 2; t++) step();
    checks++;
    if (rx_q.size() < DEPTH + 2) begin
      errors++; $display("FAIL ovf_timeout: got %0d words want %0d", rx_q.size(), DEPTH + 2);
    end else begin
      for (int i = 0; i < DEPTH + 2; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
    model_on = 1'b1;
  endtask

  task automatic test_reset_mid_record();
    bit found;
    do_reset(3);
    trace_ready = 1'b1;
    repeat (SKIP) step();
    reg_we = 1'b1; reg_waddr = 5'd5; reg_wdata = 32'h0000_0055;
    step();
    set_idle();
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (trace_valid && trace_last && trace_data == 32'h0000_0055) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_d0_seen: got none want 00000055"); end
    trace_ready = 1'b0;
    rst = 1'b1;
    step();
    checks += 3;
    if (trace_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", trace_valid); end
    if (trace_data !== 32'h0) begin errors++; $display("FAIL mid_data: got %h want 0", trace_data); end
    if (trace_last !== 1'b0) begin errors++; $display("FAIL mid_last: got %b want 0", trace_last); end
    rst = 1'b0;
    exp_q.delete();
    trace_ready = 1'b1;
    reg_we = 1'b1; reg_waddr = 5'd1; reg_wdata = 32'hFFFF_0000;
    repeat (SKIP) begin
      step();
      checks++;
      if (trace_valid !== 1'b0) begin errors++; $display("FAIL mid_warmup_valid: got %b want 0", trace_valid); end
    end
    set_idle();
    cp0_we = 1'b1; cp0_waddr = 5'd9; cp0_wdata = 32'h0BAD_F00D;
    step();
    set_idle();
    checks++;
    if (trace_valid !== 1'b0) begin errors++; $display("FAIL mid_latency_valid: got %b want 0", trace_valid); end
    for (int t = 0; t < 100 && rx_q.size() < 2; t++) step();
    checks++;
    if (rx_q.size() < 2) begin
      errors++; $display("FAIL mid_timeout: got %0d words want 2", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 33'h0_D200_0001) begin errors++; $display("FAIL mid_restart_header: got %h want 0d2000001", rx_q[0]); end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_word[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup_reg();
    test_hilo_backpressure();
    test_priority();
    test_cp0_skip();
    test_overflow();
    test_reset_mid_record();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
